// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - 4-LED pattern controller with debounced mode button and step timer
module led_mode_ctrl #(
    parameter int STEP_MAX = 24_999_999,
    parameter int DEB_MAX  = 999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_n,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       step_tick
);

    localparam int STEP_W = (STEP_MAX > 1) ? $clog2(STEP_MAX + 1) : 1;
    localparam int DEB_W  = (DEB_MAX > 2) ? $clog2(DEB_MAX) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_MAX);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_HELD,
        S_REL
    } deb_state_t;

    logic              r_key_meta;
    logic              r_key_s;
    deb_state_t        r_deb_state;
    deb_state_t        w_deb_next;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [DEB_W-1:0]  w_deb_cnt_next;
    logic              w_press;
    logic [STEP_W-1:0] r_step_cnt;
    logic              w_tick;
    logic [3:0]        r_led;
    logic [3:0]        w_led_next;
    logic [1:0]        r_mode;
    logic [1:0]        w_mode_next;
    logic              r_dir;
    logic              w_dir_next;

    function automatic logic [3:0] init_pattern(input logic [1:0] m);
        case (m)
            2'd0:    init_pattern = 4'b0001;
            2'd1:    init_pattern = 4'b1000;
            2'd2:    init_pattern = 4'b1111;
            default: init_pattern = 4'b0001;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        is_onehot = (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_key_meta <= 1'b1;
            r_key_s    <= 1'b1;
        end else begin
            r_key_meta <= key_n;
            r_key_s    <= r_key_meta;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_deb_state <= S_IDLE;
            r_deb_cnt   <= '0;
        end else begin
            r_deb_state <= w_deb_next;
            r_deb_cnt   <= w_deb_cnt_next;
        end
    end

    // Press fires only on the S_PRESS -> S_HELD edge, so holding never repeats.
    always_comb begin
        w_deb_next     = r_deb_state;
        w_deb_cnt_next = r_deb_cnt;
        w_press        = 1'b0;
        case (r_deb_state)
            S_IDLE: begin
                if (!r_key_s) begin
                    w_deb_next     = S_PRESS;
                    w_deb_cnt_next = '0;
                end
            end
            S_PRESS: begin
                if (r_key_s) begin
                    w_deb_next = S_IDLE;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_deb_next = S_HELD;
                    w_press    = 1'b1;
                end else begin
                    w_deb_cnt_next = r_deb_cnt + 1'b1;
                end
            end
            S_HELD: begin
                if (r_key_s) begin
                    w_deb_next     = S_REL;
                    w_deb_cnt_next = '0;
                end
            end
            S_REL: begin
                if (!r_key_s) begin
                    w_deb_next = S_HELD;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_deb_next = S_IDLE;
                end else begin
                    w_deb_cnt_next = r_deb_cnt + 1'b1;
                end
            end
            default: w_deb_next = S_IDLE;
        endcase
    end

    assign w_tick = (r_step_cnt == STEP_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_step_cnt <= '0;
        end else if (w_press || w_tick) begin
            r_step_cnt <= '0;
        end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
        end
    end

    // A press outranks a coincident tick: the tick's advance is dropped.
    always_comb begin
        w_led_next  = r_led;
        w_mode_next = r_mode;
        w_dir_next  = r_dir;
        if (w_press) begin
            w_mode_next = r_mode + 2'd1;
            w_led_next  = init_pattern(r_mode + 2'd1);
            w_dir_next  = 1'b1;
        end else if (w_tick) begin
            case (r_mode)
                2'd0: begin
                    if (is_onehot(r_led)) w_led_next = {r_led[2:0], r_led[3]};
                    else                  w_led_next = init_pattern(r_mode);
                end
                2'd1: begin
                    if (is_onehot(r_led)) w_led_next = {r_led[0], r_led[3:1]};
                    else                  w_led_next = init_pattern(r_mode);
                end
                2'd2: begin
                    if (r_led == 4'b0000 || r_led == 4'b1111) w_led_next = ~r_led;
                    else                                      w_led_next = init_pattern(r_mode);
                end
                default: begin
                    if (!is_onehot(r_led)) begin
                        w_led_next = init_pattern(r_mode);
                    end else if (r_dir) begin
                        if (r_led == 4'b1000) begin
                            w_led_next = 4'b0100;
                            w_dir_next = 1'b0;
                        end else begin
                            w_led_next = r_led << 1;
                        end
                    end else begin
                        if (r_led == 4'b0001) begin
                            w_led_next = 4'b0010;
                            w_dir_next = 1'b1;
                        end else begin
                            w_led_next = r_led >> 1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_led  <= 4'b0001;
            r_mode <= 2'd0;
            r_dir  <= 1'b1;
        end else begin
            r_led  <= w_led_next;
            r_mode <= w_mode_next;
            r_dir  <= w_dir_next;
        end
    end

    assign led       = r_led;
    assign mode      = r_mode;
    assign step_tick = w_tick;

endmodule
